down_count_monitor: RTL and testbench

- Downstream consumer of a WIDTH-bit synchronous down counter's output bus.
- Samples the count and checks each step is exactly "previous minus one" (mod 2^WIDTH).
- Declares lock after a run of good steps, flags/counts step errors once locked, and detects/counts wrap events (0 -> all-ones).
- Provides a self-check and board-debug visibility for the counter stage.

---
 rtl/down_count_monitor.sv | 144 ++++++++++++++
 tb/tb_down_count_monitor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/down_count_monitor.sv
// rtl/down_count_monitor.sv - step/lock/wrap checker for a down counter's output bus; optional macro DCM_STALL_TOLERATE_EN
module down_count_monitor #(
    parameter int WIDTH       = 4,
    parameter int ERR_CNT_W   = 8,
    parameter int WRAP_CNT_W  = 8,
    parameter int LOCK_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  sample_en,
    input  logic                  clear,
    output logic                  locked,
    output logic                  step_err,
    output logic                  wrap_pulse,
    output logic                  err_flag,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [WRAP_CNT_W-1:0] wrap_count
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] THRESH = 4'(LOCK_THRESH);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      prev_q, prev_d;
    logic [3:0]            good_run_q, good_run_d;
    logic                  locked_q, locked_d;
    logic                  step_err_q, step_err_d;
    logic                  wrap_q, wrap_d;
    logic                  err_flag_q, err_flag_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;

    logic [WIDTH-1:0]      prev_dec;
    logic                  step_good;
    logic                  is_wrap;
    logic                  stall_hold;

    assign prev_dec  = prev_q - WIDTH'(1);
    assign step_good = (count_in == prev_dec);
    assign is_wrap   = (prev_q == '0) && (count_in == '1);

`ifdef DCM_STALL_TOLERATE_EN
    // A repeated value is treated as the counter pausing: nothing moves.
    assign stall_hold = (count_in == prev_q);
`else
    assign stall_hold = 1'b0;
`endif

    // Next-state: FSM advances only on sampled cycles; clear overrides the counters and flag.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_run_d   = good_run_q;
        step_err_d   = 1'b0;
        wrap_d       = 1'b0;
        err_flag_d   = err_flag_q;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;

        if (sample_en) begin
            case (state_q)
                ST_EMPTY: begin
                    prev_d     = count_in;
                    good_run_d = 4'd0;
                    state_d    = ST_ACQUIRE;
                end
                default: begin
                    if (!stall_hold) begin
                        prev_d = count_in;
                        if (is_wrap) begin
                            wrap_d       = 1'b1;
                            wrap_count_d = wrap_count_q + WRAP_CNT_W'(1);
                        end
                        if (step_good) begin
                            if (state_q == ST_ACQUIRE) begin
                                good_run_d = good_run_q + 4'd1;
                                if (good_run_q + 4'd1 == THRESH) begin
                                    state_d = ST_LOCKED;
                                end
                            end
                        end else begin
                            good_run_d = 4'd0;
                            if (state_q == ST_LOCKED) begin
                                step_err_d = 1'b1;
                                err_flag_d = 1'b1;
                                state_d    = ST_ACQUIRE;
                                if (err_count_q != '1) begin
                                    err_count_d = err_count_q + ERR_CNT_W'(1);
                                end
                            end
                        end
                    end
                end
            endcase
        end

        if (clear) begin
            err_flag_d   = 1'b0;
            err_count_d  = '0;
            wrap_count_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            prev_q       <= '0;
            good_run_q   <= 4'd0;
            locked_q     <= 1'b0;
            step_err_q   <= 1'b0;
            wrap_q       <= 1'b0;
            err_flag_q   <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_run_q   <= good_run_d;
            locked_q     <= locked_d;
            step_err_q   <= step_err_d;
            wrap_q       <= wrap_d;
            err_flag_q   <= err_flag_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign locked     = locked_q;
    assign step_err   = step_err_q;
    assign wrap_pulse = wrap_q;
    assign err_flag   = err_flag_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// tb/tb_down_count_monitor.sv - vector table plus scoreboard bench for down_count_monitor
module tb_down_count_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] count_in;
    logic       sample_en;
    logic       clear;

    logic       locked, step_err, wrap_pulse, err_flag;
    logic [7:0] err_count, wrap_count;

    logic       s_locked, s_step_err, s_wrap_pulse, s_err_flag;
    logic [1:0] s_err_count;
    logic [7:0] s_wrap_count;

`ifdef DCM_STALL_TOLERATE_EN
    localparam bit STALL_BAD = 1'b0;
`else
    localparam bit STALL_BAD = 1'b1;
`endif

    down_count_monitor #(.WIDTH(4), .ERR_CNT_W(8), .WRAP_CNT_W(8), .LOCK_THRESH(2)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en), .clear(clear),
        .locked(locked), .step_err(step_err), .wrap_pulse(wrap_pulse), .err_flag(err_flag),
        .err_count(err_count), .wrap_count(wrap_count)
    );

    down_count_monitor #(.WIDTH(4), .ERR_CNT_W(2), .WRAP_CNT_W(8), .LOCK_THRESH(2)) dut_sat (
        .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en), .clear(clear),
        .locked(s_locked), .step_err(s_step_err), .wrap_pulse(s_wrap_pulse), .err_flag(s_err_flag),
        .err_count(s_err_count), .wrap_count(s_wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       se;
        logic       clr;
        logic [3:0] cnt;
        logic       l;
        logic       st;
        logic       wp;
        logic       ef;
        logic [7:0] ec;
        logic [7:0] wc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(string nm, logic r, logic se, logic clr, logic [3:0] c,
                                logic l, logic st, logic wp, logic ef, int ec, int wc);
        vec_t v;
        v.name = nm; v.rst = r; v.se = se; v.clr = clr; v.cnt = c;
        v.l = l; v.st = st; v.wp = wp; v.ef = ef; v.ec = 8'(ec); v.wc = 8'(wc);
        return v;
    endfunction

    function void add(string nm, logic r, logic se, logic clr, logic [3:0] c,
                      logic l, logic st, logic wp, logic ef, int ec, int wc);
        vecs.push_back(mk(nm, r, se, clr, c, l, st, wp, ef, ec, wc));
    endfunction

    task automatic check_out();
        vec_t        e;
        logic [19:0] act, exp;
        logic [1:0]  exp_sat;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got no expected entry, need one");
        end else begin
            e   = sb_q.pop_front();
            act = {locked, step_err, wrap_pulse, err_flag, err_count, wrap_count};
            exp = {e.l, e.st, e.wp, e.ef, e.ec, e.wc};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL %s: got l=%0b st=%0b wp=%0b ef=%0b ec=%0d wc=%0d, need l=%0b st=%0b wp=%0b ef=%0b ec=%0d wc=%0d",
                         e.name, locked, step_err, wrap_pulse, err_flag, err_count, wrap_count,
                         e.l, e.st, e.wp, e.ef, e.ec, e.wc);
            end
            exp_sat = (e.ec > 8'd3) ? 2'd3 : e.ec[1:0];
            checks++;
            if (s_err_count !== exp_sat || s_step_err !== e.st || s_err_flag !== e.ef) begin
                failures++;
                $display("FAIL %s_sat: got ec=%0d st=%0b ef=%0b, need ec=%0d st=%0b ef=%0b",
                         e.name, s_err_count, s_step_err, s_err_flag, exp_sat, e.st, e.ef);
            end
        end
    endtask

    task automatic drive(vec_t v);
        rst       = v.rst;
        sample_en = v.se;
        clear     = v.clr;
        count_in  = v.cnt;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] trip [5];
        logic [3:0] b;
        int         e_stall;

        rst = 1'b1; sample_en = 1'b0; clear = 1'b0; count_in = 4'd0;
        e_stall = STALL_BAD ? 2 : 1;
        trip[0] = 4'd10; trip[1] = 4'd13; trip[2] = 4'd6; trip[3] = 4'd14; trip[4] = 4'd3;

        add("reset0", 1, 0, 0, 4'($urandom_range(15)), 0, 0, 0, 0, 0, 0);
        add("reset1", 1, 1, 0, 4'($urandom_range(15)), 0, 0, 0, 0, 0, 0);
        add("acq15",  0, 1, 0, 4'd15, 0, 0, 0, 0, 0, 0);
        add("acq14",  0, 1, 0, 4'd14, 0, 0, 0, 0, 0, 0);
        add("lock13", 0, 1, 0, 4'd13, 1, 0, 0, 0, 0, 0);
        for (int v = 12; v >= 0; v--) add("run_down", 0, 1, 0, 4'(v), 1, 0, 0, 0, 0, 0);
        add("wrap15", 0, 1, 0, 4'd15, 1, 0, 1, 0, 0, 1);
        add("post_wrap14", 0, 1, 0, 4'd14, 1, 0, 0, 0, 0, 1);
        add("idle_garbage3", 0, 0, 0, 4'd3, 1, 0, 0, 0, 0, 1);
        add("idle_garbage0", 0, 0, 0, 4'd0, 1, 0, 0, 0, 0, 1);
        for (int v = 13; v >= 9; v--) add("run_to9", 0, 1, 0, 4'(v), 1, 0, 0, 0, 0, 1);
        add("bad_jump5", 0, 1, 0, 4'd5, 0, 1, 0, 1, 1, 1);
        add("reacq4",    0, 1, 0, 4'd4, 0, 0, 0, 1, 1, 1);
        add("relock3",   0, 1, 0, 4'd3, 1, 0, 0, 1, 1, 1);
        for (int v = 2; v >= 0; v--) add("run_to0", 0, 1, 0, 4'(v), 1, 0, 0, 1, 1, 1);
        add("wrap15b", 0, 1, 0, 4'd15, 1, 0, 1, 1, 1, 2);
        for (int v = 14; v >= 7; v--) add("run_to7", 0, 1, 0, 4'(v), 1, 0, 0, 1, 1, 2);
        add("stall7", 0, 1, 0, 4'd7, !STALL_BAD, STALL_BAD, 0, 1, e_stall, 2);
        add("stall_idle", 0, 0, 0, 4'd11, !STALL_BAD, 0, 0, 1, e_stall, 2);
        add("after_stall6", 0, 1, 0, 4'd6, !STALL_BAD, 0, 0, 1, e_stall, 2);
        add("after_stall5", 0, 1, 0, 4'd5, 1, 0, 0, 1, e_stall, 2);
        add("clear_only", 0, 0, 1, 4'd9, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

        for (int k = 0; k < 5; k++) begin
            b = trip[k];
            drive(mk("sat_err",    0, 1, 0, b,         0, 1, 0, 1, k + 1, 0));
            drive(mk("sat_reacq",  0, 1, 0, b - 4'd1,  0, 0, 0, 1, k + 1, 0));
            drive(mk("sat_relock", 0, 1, 0, b - 4'd2,  1, 0, 0, 1, k + 1, 0));
        end
        drive(mk("err_with_clear", 0, 1, 1, 4'd9, 0, 1, 0, 0, 0, 0));
        drive(mk("clr_reacq8",     0, 1, 0, 4'd8, 0, 0, 0, 0, 0, 0));
        drive(mk("clr_relock7",    0, 1, 0, 4'd7, 1, 0, 0, 0, 0, 0));

        drive(mk("rst_priority", 1, 1, 1, 4'd6, 0, 0, 0, 0, 0, 0));
        drive(mk("empty_no_wrap", 0, 1, 0, 4'd15, 0, 0, 0, 0, 0, 0));
        drive(mk("reacq14",       0, 1, 0, 4'd14, 0, 0, 0, 0, 0, 0));
        for (int v = 13; v >= 0; v--) drive(mk("relock_run", 0, 1, 0, 4'(v), 1, 0, 0, 0, 0, 0));
        drive(mk("wrap_with_clear", 0, 1, 1, 4'd15, 1, 0, 1, 0, 0, 0));
        drive(mk("after_clr_wrap",  0, 1, 0, 4'd14, 1, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
